logit_argmax_classifier: RTL and testbench
==========================================

Name: logit_argmax_classifier

Overview:
- Final stage of the network. Sits directly downstream of the network top's output vector (10 × signed 32-bit logits plus a one-cycle valid).
- Captures each logit vector and scans it sequentially, one element per cycle, to find the top class, its score and the top-1 minus top-2 margin.
- Presents the result on a valid/ready interface for the host or readout logic.
- Counts vectors dropped while the block is busy, because the upstream network has no backpressure.

Parameters:
- NUM_CLASSES, 10, number of logits per vector; must be ≥ 2.
- ACC_WIDTH, 32, logit width (signed two's complement).
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  logit vector present (single-cycle pulse from upstream)
- in_data  in  [NUM_CLASSES] x ACC_WIDTH signed  logit vector
- in_ready  out  1  block can capture on this edge
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_class  out  $clog2(NUM_CLASSES)  index of the maximum logit
- out_score  out  ACC_WIDTH signed  maximum logit value
- out_margin  out  ACC_WIDTH unsigned  top-1 minus top-2
- drop_count  out  CNT_WIDTH  saturating count of vectors not captured

Behaviour:
- Reset and clocking: reset rst_n, synchronous, active-low; clock clk.
- Reset values: state=IDLE, out_valid=0, out_class=0, out_score=0, out_margin=0, drop_count=0. in_ready=1 after reset (combinational from IDLE).
- Reset mid-scan or mid-hold aborts the operation; the in-flight result is discarded and never presented.
- States:
  - IDLE: in_ready=1. On in_valid: latch all NUM_CLASSES logits into vec_q, set best=in_data[0], best_idx=0, second=-2^(ACC_WIDTH-1), idx=1, go to SCAN.
  - SCAN: each cycle process x=vec_q[idx]:
    - if x>best: second=best, best=x, best_idx=idx;
    - else if x>second: second=x.
    - idx++. After processing idx=NUM_CLASSES-1, go to HOLD and register the outputs.
  - HOLD: out_valid=1; all outputs stable until handshake.
    - On out_ready: if in_valid that same cycle, capture the new vector (identical to IDLE capture) and go to SCAN; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This supports back-to-back capture on the accept edge.
- Latency: out_valid rises NUM_CLASSES-1 cycles after the capture edge (9 for the default). Throughput is one vector per NUM_CLASSES cycles when out_ready is held at 1.
- Comparisons are signed. Ties keep the lowest index (strict >).
- A duplicate maximum yields second=best, so margin=0.
- Margin: best−second computed at ACC_WIDTH+1 bits. The result is always ≥0 and ≤2^ACC_WIDTH−1, so it is output as the low ACC_WIDTH bits, unsigned.
- Drop counting:
  - in_valid & !in_ready increments drop_count, saturating at all-ones.
  - The vector is not captured and the in-progress scan is unaffected.
- out_valid never deasserts without out_ready, except on reset.

Decomposition:
- Shared package nn_pkg:
  - ACC_WIDTH/NUM_CLASSES defaults;
  - typedef logit_t (signed ACC_WIDTH);
  - typedef class_idx_t;
  - constant LOGIT_MIN = -2^(ACC_WIDTH-1);
  - enum argmax_state_t {IDLE, SCAN, HOLD}.
- One sub-module, argmax_update: combinational compare-and-update of (best, best_idx, second) given x and idx, reusable elsewhere.
- The FSM, capture register and drop counter stay in the top of this block.

Test Plan:
- Distinct logits, max at index 7:
  - Stimulus: logits {5,-3,12,0,8,1,2,300,-1000,299}, out_ready=1.
  - Response: out_valid after 9 cycles; class=7, score=300, margin=1.
- Ties:
  - Stimulus: all logits = -5.
  - Response: class=0, score=-5, margin=0.
  - Stimulus: logits[2]=logits[6]=100, others 0.
  - Response: class=2, margin=0.
- Extremes:
  - Stimulus: logits[0]=-2^31, logits[9]=2^31−1, others -2^31.
  - Response: class=9, margin=0xFFFFFFFF.
- Backpressure and drop:
  - Stimulus: out_ready=0; second in_valid arrives 3 cycles after first capture; third arrives during HOLD.
  - Response: first result held unchanged; drop_count=2; after out_ready, in_ready=1 and the next capture works.
- Back-to-back:
  - Stimulus: out_ready=1; in_valid on the same cycle out_valid&out_ready.
  - Response: new vector captured, drop_count unchanged, next result 9 cycles later.
- Reset mid-scan:
  - Stimulus: rst_n=0 at scan cycle 4.
  - Response: all outputs 0; no out_valid until a new vector is captured.
- Drop counter saturation:
  - Stimulus: hold the block busy and force 0xFFFF+3 drops.
  - Response: drop_count=0xFFFF.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared network definitions: default widths, logit/class types and the
// argmax classifier state encoding.
package nn_pkg;

    localparam int DEFAULT_NUM_CLASSES = 10;
    localparam int DEFAULT_ACC_WIDTH   = 32;

    typedef logic signed [DEFAULT_ACC_WIDTH-1:0]       logit_t;
    typedef logic [$clog2(DEFAULT_NUM_CLASSES)-1:0]    class_idx_t;

    localparam logit_t LOGIT_MIN = {1'b1, {(DEFAULT_ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } argmax_state_t;

endpackage

// File: rtl/argmax_update.sv
// One step of a running top-2 search: folds candidate x (at index idx) into
// the current (best, best_idx, second). Strict compares keep the lowest index on ties.
module argmax_update #(
    parameter int ACC_WIDTH = 32,
    parameter int IDX_WIDTH = 4
) (
    input  logic signed [ACC_WIDTH-1:0] best,
    input  logic        [IDX_WIDTH-1:0] best_idx,
    input  logic signed [ACC_WIDTH-1:0] second,
    input  logic signed [ACC_WIDTH-1:0] x,
    input  logic        [IDX_WIDTH-1:0] idx,
    output logic signed [ACC_WIDTH-1:0] next_best,
    output logic        [IDX_WIDTH-1:0] next_best_idx,
    output logic signed [ACC_WIDTH-1:0] next_second
);

    always_comb begin
        next_best     = best;
        next_best_idx = best_idx;
        next_second   = second;
        if (x > best) begin
            next_second   = best;
            next_best     = x;
            next_best_idx = idx;
        end else if (x > second) begin
            next_second = x;
        end
    end

endmodule

// File: rtl/logit_argmax_classifier.sv
// Captures a logit vector, scans it one element per cycle for the top class,
// score and top-1/top-2 margin, and holds the result on a valid/ready output.
module logit_argmax_classifier
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0]   in_data,
    output logic                                    in_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]          out_class,
    output logic signed [ACC_WIDTH-1:0]             out_score,
    output logic [ACC_WIDTH-1:0]                    out_margin,
    output logic [CNT_WIDTH-1:0]                    drop_count
);

    localparam int IDX_WIDTH = $clog2(NUM_CLASSES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_LOGIT = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    argmax_state_t state_q, state_d;

    logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] vec_q;
    logic signed [ACC_WIDTH-1:0] best_q, second_q, x;
    logic signed [ACC_WIDTH-1:0] nxt_best, nxt_second;
    logic [IDX_WIDTH-1:0]        best_idx_q, idx_q, nxt_best_idx;
    logic [ACC_WIDTH-1:0]        margin;
    logic                        capture, finish;

    assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign out_valid = (state_q == HOLD);
    assign capture   = in_valid & in_ready;
    assign x         = vec_q[idx_q];

    // best >= second always holds, so the low ACC_WIDTH bits of the wide
    // difference are exactly the unsigned margin.
    assign margin = nxt_best - nxt_second;

    argmax_update #(
        .ACC_WIDTH (ACC_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_update (
        .best          (best_q),
        .best_idx      (best_idx_q),
        .second        (second_q),
        .x             (x),
        .idx           (idx_q),
        .next_best     (nxt_best),
        .next_best_idx (nxt_best_idx),
        .next_second   (nxt_second)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: if (capture) state_d = SCAN;
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (out_ready) state_d = capture ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture and scan never coincide: in_ready is low throughout SCAN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            second_q   <= '0;
            idx_q      <= '0;
            out_class  <= '0;
            out_score  <= '0;
            out_margin <= '0;
            drop_count <= '0;
        end else begin
            if (capture) begin
                vec_q      <= in_data;
                best_q     <= in_data[0];
                best_idx_q <= '0;
                second_q   <= MIN_LOGIT;
                idx_q      <= IDX_WIDTH'(1);
            end else if (state_q == SCAN) begin
                best_q     <= nxt_best;
                best_idx_q <= nxt_best_idx;
                second_q   <= nxt_second;
                idx_q      <= idx_q + IDX_WIDTH'(1);
            end
            if (finish) begin
                out_class  <= nxt_best_idx;
                out_score  <= nxt_best;
                out_margin <= margin;
            end
            if (in_valid && !in_ready && (drop_count != '1))
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_logit_argmax_classifier.sv
// Directed self-checking bench for logit_argmax_classifier: results, ties,
// extremes, backpressure/drops, back-to-back capture, reset abort, saturation.
module tb_logit_argmax_classifier;

    localparam int NC = 10;
    localparam int AW = 32;
    localparam int CW = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       out_ready = 1'b1;
    logic [NC-1:0][AW-1:0]      in_data = '0;
    logic                       in_ready;
    logic                       out_valid;
    logic [3:0]                 out_class;
    logic signed [AW-1:0]       out_score;
    logic [AW-1:0]              out_margin;
    logic [CW-1:0]              drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [AW-1:0] vec [NC];

    logit_argmax_classifier #(
        .NUM_CLASSES (NC),
        .ACC_WIDTH   (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_score  (out_score),
        .out_margin (out_margin),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents vec as a one-cycle in_valid pulse.
    task automatic applyStimulus();
        for (int i = 0; i < NC; i++) in_data[i] = vec[i];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic checkResult(input string tag, input int cls, input logic [31:0] score,
                               input logic [31:0] margin);
        checkOutput({tag, "_valid"},  32'(out_valid), 1);
        checkOutput({tag, "_class"},  32'(out_class), cls);
        checkOutput({tag, "_score"},  out_score, score);
        checkOutput({tag, "_margin"}, out_margin, margin);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        checkOutput("rst_valid",  32'(out_valid), 0);
        checkOutput("rst_class",  32'(out_class), 0);
        checkOutput("rst_score",  out_score, 0);
        checkOutput("rst_margin", out_margin, 0);
        checkOutput("rst_drop",   32'(drop_count), 0);
        checkOutput("rst_ready",  32'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        // Distinct logits, max at index 7
        vec = '{5, -3, 12, 0, 8, 1, 2, 300, -1000, 299};
        applyStimulus();
        checkOutput("distinct_busy", 32'(in_ready), 0);
        waitResult("distinct", 9);
        checkResult("distinct", 7, 300, 1);
        tick();
        checkOutput("distinct_release", 32'(out_valid), 0);
        checkOutput("idle_ready", 32'(in_ready), 1);

        // All equal
        vec = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
        applyStimulus();
        waitResult("alleq", 9);
        checkResult("alleq", 0, 32'hFFFF_FFFB, 0);
        tick();

        // Duplicate maximum
        vec = '{0, 0, 100, 0, 0, 0, 100, 0, 0, 0};
        applyStimulus();
        waitResult("dupmax", 9);
        checkResult("dupmax", 2, 100, 0);
        tick();

        // Extremes
        for (int i = 0; i < NC; i++) vec[i] = 32'sh8000_0000;
        vec[9] = 32'sh7FFF_FFFF;
        applyStimulus();
        waitResult("extreme", 9);
        checkResult("extreme", 9, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        tick();

        // Backpressure: one drop during scan, one during hold
        out_ready = 1'b0;
        vec = '{40, 10, 20, 30, 0, 0, 0, 0, 0, -1};
        applyStimulus();
        tick();
        tick();
        vec = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 99};
        applyStimulus();
        checkOutput("bp_drop1", 32'(drop_count), 1);
        waitResult("bp", 6);
        checkResult("bp", 0, 40, 10);
        tick();
        tick();
        applyStimulus();
        checkOutput("bp_drop2", 32'(drop_count), 2);
        checkOutput("bp_hold_ready", 32'(in_ready), 0);
        checkResult("bp_held", 0, 40, 10);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_accept_ready", 32'(in_ready), 1);
        vec = '{7, 7000, -7, 6000, 0, 0, 0, 0, 0, 0};
        applyStimulus();
        checkOutput("bp_recapture", 32'(out_valid), 0);
        waitResult("bp_next", 9);
        checkResult("bp_next", 1, 7000, 1000);

        // Back-to-back capture on the accept edge
        vec = '{-100, -60, -75, -60, -50, -55, -99, -54, -80, -70};
        applyStimulus();
        checkOutput("b2b_scan", 32'(out_valid), 0);
        checkOutput("b2b_drop", 32'(drop_count), 2);
        waitResult("b2b", 9);
        checkResult("b2b", 4, 32'hFFFF_FFCE, 4);
        tick();

        // Reset during scan discards the in-flight result
        vec = '{40, 10, 20, 30, 0, 0, 0, 0, 0, -1};
        applyStimulus();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_valid",  32'(out_valid), 0);
        checkOutput("midrst_class",  32'(out_class), 0);
        checkOutput("midrst_score",  out_score, 0);
        checkOutput("midrst_margin", out_margin, 0);
        checkOutput("midrst_drop",   32'(drop_count), 0);
        checkOutput("midrst_ready",  32'(in_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid) seen++;
            end
            checkOutput("midrst_no_result", seen, 0);
        end

        // Drop counter saturation
        out_ready = 1'b0;
        applyStimulus();
        in_valid = 1'b1;
        repeat (65534) tick();
        checkOutput("sat_below", 32'(drop_count), 32'hFFFE);
        repeat (4) tick();
        in_valid = 1'b0;
        checkOutput("sat_full", 32'(drop_count), 32'hFFFF);
        checkResult("sat_held", 0, 40, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
